mem_rr_arbiter: RTL and testbench

MEM_RR_ARBITER -- requirements
Module: mem_rr_arbiter

---
 rtl/mem_rr_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_mem_rr_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: round-robin arbiter of PORTS requesters onto one memory port.
// Ports: slave_command_* (requesters in), slave_result_* (read data out),
//   master_command_* (registered command to memory), master_result_* (in-order
//   read data from memory). Optional MEM_RR_ARBITER_PERF_EN adds grant_count_o
//   and fifo_full_cycles_o performance counters.
module mem_rr_arbiter #(
   parameter int PORTS           = 2,
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [PORTS-1:0]                 slave_command_valid_i,
   output logic [PORTS-1:0]                 slave_command_ready_o,
   input  logic [PORTS-1:0]                 slave_command_read_enable_i,
   input  logic [PORTS-1:0]                 slave_command_write_enable_i,
   input  logic [PORTS-1:0][ADDR_WIDTH-1:0] slave_command_addr_i,
   input  logic [PORTS-1:0][DATA_WIDTH-1:0] slave_command_data_i,
   output logic [PORTS-1:0]                 slave_result_valid_o,
   input  logic [PORTS-1:0]                 slave_result_ready_i,
   output logic [PORTS-1:0][DATA_WIDTH-1:0] slave_result_data_o,
   output logic                             master_command_valid_o,
   input  logic                             master_command_ready_i,
   output logic                             master_command_read_enable_o,
   output logic                             master_command_write_enable_o,
   output logic [ADDR_WIDTH-1:0]            master_command_addr_o,
   output logic [DATA_WIDTH-1:0]            master_command_data_o,
   input  logic                             master_result_valid_i,
   output logic                             master_result_ready_o,
   input  logic [DATA_WIDTH-1:0]            master_result_data_i
`ifdef MEM_RR_ARBITER_PERF_EN
   ,
   output logic [PORTS-1:0][31:0]           grant_count_o,
   output logic [31:0]                      fifo_full_cycles_o
`endif
);

   localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;
   localparam int FW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int CW = $clog2(MAX_OUTSTANDING + 1);

   function automatic logic [FW-1:0] ptr_inc(input logic [FW-1:0] p);
      return (int'(p) == MAX_OUTSTANDING - 1) ? '0 : p + FW'(1);
   endfunction

   logic [PW-1:0]         last_q, last_d;
   logic [CW-1:0]         count_q, count_d;
   logic [FW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [FW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         fifo_q [MAX_OUTSTANDING];
   logic                  out_valid_q, out_valid_d;
   logic                  out_re_q, out_re_d;
   logic                  out_we_q, out_we_d;
   logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

   logic             full, empty, pop, push, drain, room, rd_ok, gnt;
   logic             gnt_found;
   logic [PW-1:0]    gnt_idx;
   logic [PW-1:0]    head;
   logic [PORTS-1:0] eligible;
   int unsigned      cand;

   assign full  = (count_q == CW'(MAX_OUTSTANDING));
   assign empty = (count_q == '0);
   assign head  = fifo_q[rd_ptr_q];

   // Responses are steered to the port that issued the oldest open read.
   assign master_result_ready_o = !rst && !empty && slave_result_ready_i[head];
   assign pop   = master_result_valid_i && master_result_ready_o;

   assign drain = out_valid_q && master_command_ready_i;
   assign room  = !rst && (!out_valid_q || drain);
   // A pop this cycle frees a slot for a read granted in the same cycle.
   assign rd_ok = !full || pop;

   always_comb begin
      eligible = '0;
      for (int i = 0; i < PORTS; i++) begin
         eligible[i] = slave_command_valid_i[i] &&
                       (!slave_command_read_enable_i[i] || rd_ok);
      end
   end

   // Search starts one past the last granted port.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = 0;
      for (int k = 1; k <= PORTS; k++) begin
         cand = (int'(last_q) + k) % PORTS;
         if (!gnt_found && eligible[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = PW'(cand);
         end
      end
   end

   assign gnt  = room && gnt_found;
   assign push = gnt && slave_command_read_enable_i[gnt_idx];

   always_comb begin
      slave_command_ready_o = '0;
      if (gnt) slave_command_ready_o[gnt_idx] = 1'b1;
   end

   always_comb begin
      slave_result_valid_o = '0;
      for (int i = 0; i < PORTS; i++) begin
         slave_result_data_o[i] = master_result_data_i;
      end
      if (!rst && !empty && master_result_valid_i) begin
         slave_result_valid_o[head] = 1'b1;
      end
   end

   always_comb begin
      last_d      = gnt ? gnt_idx : last_q;
      rd_ptr_d    = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      wr_ptr_d    = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      count_d     = count_q;
      if (push && !pop) count_d = count_q + CW'(1);
      if (pop && !push) count_d = count_q - CW'(1);
      out_valid_d = out_valid_q && !drain;
      out_re_d    = out_re_q;
      out_we_d    = out_we_q;
      out_addr_d  = out_addr_q;
      out_data_d  = out_data_q;
      if (gnt) begin
         out_valid_d = 1'b1;
         out_re_d    = slave_command_read_enable_i[gnt_idx];
         out_we_d    = slave_command_write_enable_i[gnt_idx];
         out_addr_d  = slave_command_addr_i[gnt_idx];
         out_data_d  = slave_command_data_i[gnt_idx];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_q      <= PW'(PORTS - 1);
         count_q     <= '0;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         out_valid_q <= 1'b0;
         out_re_q    <= 1'b0;
         out_we_q    <= 1'b0;
         out_addr_q  <= '0;
         out_data_q  <= '0;
      end else begin
         last_q      <= last_d;
         count_q     <= count_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         out_valid_q <= out_valid_d;
         out_re_q    <= out_re_d;
         out_we_q    <= out_we_d;
         out_addr_q  <= out_addr_d;
         out_data_q  <= out_data_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_q[wr_ptr_q] <= gnt_idx;
   end

   assign master_command_valid_o        = out_valid_q && !rst;
   assign master_command_read_enable_o  = out_re_q;
   assign master_command_write_enable_o = out_we_q;
   assign master_command_addr_o         = out_addr_q;
   assign master_command_data_o         = out_data_q;

`ifdef MEM_RR_ARBITER_PERF_EN
   logic [PORTS-1:0][31:0] grant_count_q;
   logic [31:0]            fifo_full_cycles_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         grant_count_q      <= '0;
         fifo_full_cycles_q <= '0;
      end else begin
         if (gnt) grant_count_q[gnt_idx] <= grant_count_q[gnt_idx] + 32'd1;
         if (full) fifo_full_cycles_q <= fifo_full_cycles_q + 32'd1;
      end
   end

   assign grant_count_o      = grant_count_q;
   assign fifo_full_cycles_o = fifo_full_cycles_q;
`endif

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Bench for mem_rr_arbiter: transaction-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_mem_rr_arbiter;

   localparam int P  = 2;
   localparam int MO = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic [1:0]       s_valid, s_ready, s_re, s_we, s_rvalid, s_rready;
   logic [1:0][31:0] s_addr, s_data, s_rdata;
   logic             m_cvalid, m_cready, m_cre, m_cwe;
   logic [31:0]      m_caddr, m_cdata;
   logic             m_rvalid, m_rready;
   logic [31:0]      m_rdata;
`ifdef MEM_RR_ARBITER_PERF_EN
   logic [1:0][31:0] gcnt;
   logic [31:0]      ffc;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   mem_rr_arbiter dut (
      .clk                           (clk),
      .rst                           (rst),
      .slave_command_valid_i         (s_valid),
      .slave_command_ready_o         (s_ready),
      .slave_command_read_enable_i   (s_re),
      .slave_command_write_enable_i  (s_we),
      .slave_command_addr_i          (s_addr),
      .slave_command_data_i          (s_data),
      .slave_result_valid_o          (s_rvalid),
      .slave_result_ready_i          (s_rready),
      .slave_result_data_o           (s_rdata),
      .master_command_valid_o        (m_cvalid),
      .master_command_ready_i        (m_cready),
      .master_command_read_enable_o  (m_cre),
      .master_command_write_enable_o (m_cwe),
      .master_command_addr_o         (m_caddr),
      .master_command_data_o         (m_cdata),
      .master_result_valid_i         (m_rvalid),
      .master_result_ready_o         (m_rready),
      .master_result_data_i          (m_rdata)
`ifdef MEM_RR_ARBITER_PERF_EN
      ,
      .grant_count_o                 (gcnt),
      .fifo_full_cycles_o            (ffc)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Model: last granted port, one-deep command buffer, queue of open reads.
   int          last = P - 1;
   bit          mb_v = 1'b0;
   logic        mb_re, mb_we;
   logic [31:0] mb_addr, mb_data;
   int          rq[$];
   int          glog[$];
   int          rlog[$];
   logic [31:0] mlog[$];
   int          g, p;
   bit          drain, room, popok, pop;
   logic [1:0]  exp_rv, exp_sr;

   always @(negedge clk) begin
      if (rst) begin
         chk("rst_mvalid", m_cvalid, 0);
         chk("rst_sready", s_ready, 0);
         chk("rst_rvalid", s_rvalid, 0);
         chk("rst_mrready", m_rready, 0);
         mb_v = 1'b0;
         last = P - 1;
         rq.delete();
      end else begin
         chk("m_cvalid", m_cvalid, mb_v);
         if (mb_v) begin
            chk("m_caddr", m_caddr, mb_addr);
            chk("m_cdata", m_cdata, mb_data);
            chk("m_cre", m_cre, mb_re);
            chk("m_cwe", m_cwe, mb_we);
         end
         drain = mb_v && m_cready;
         room  = !mb_v || drain;
         popok = (rq.size() > 0) && s_rready[rq[0]];
         chk("m_rready", m_rready, popok);
         pop = popok && m_rvalid;
         exp_rv = '0;
         if (m_rvalid && rq.size() > 0) begin
            exp_rv[rq[0]] = 1'b1;
            chk("s_rdata", s_rdata[rq[0]], m_rdata);
         end
         chk("s_rvalid", s_rvalid, exp_rv);
         g = -1;
         if (room) begin
            for (int k = 1; k <= P; k++) begin
               p = (last + k) % P;
               if (g < 0 && s_valid[p] &&
                   (!s_re[p] || rq.size() < MO || pop)) g = p;
            end
         end
         exp_sr = '0;
         if (g >= 0) exp_sr[g] = 1'b1;
         chk("s_ready", s_ready, exp_sr);
         if (pop) begin
            rlog.push_back(rq[0]);
            void'(rq.pop_front());
         end
         if (drain) begin
            mlog.push_back(mb_addr);
            mb_v = 1'b0;
         end
         if (g >= 0) begin
            mb_v    = 1'b1;
            mb_addr = s_addr[g];
            mb_data = s_data[g];
            mb_re   = s_re[g];
            mb_we   = s_we[g];
            last    = g;
            glog.push_back(g);
            if (s_re[g]) rq.push_back(g);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
      #1;
   endtask

   int g0, m0;
   int exp_g[4] = '{0, 1, 0, 1};
   logic [31:0] exp_m[4] = '{32'hA0, 32'hB0, 32'hA0, 32'hB0};

   initial begin
      s_valid = '0; s_re = '0; s_we = '0;
      s_addr = '0; s_data = '0; s_rready = 2'b11;
      m_cready = 1'b1; m_rvalid = 1'b0; m_rdata = '0;

      tick(); tick();
      mid();
      chk("reset_mvalid", m_cvalid, 0);
      chk("reset_mrready", m_rready, 0);
      tick();
      rst = 1'b0;

      // Alternating grants, both ports always valid.
      g0 = glog.size(); m0 = mlog.size();
      s_valid = 2'b11; s_we = 2'b11; s_re = 2'b00;
      s_addr[0] = 32'hA0; s_addr[1] = 32'hB0;
      s_data[0] = 32'h1234; s_data[1] = 32'h5678;
      repeat (4) tick();
      s_valid = 2'b00;
      for (int i = 0; i < 4; i++) chk("alt_grant", glog[g0+i], exp_g[i]);
      tick();
      for (int i = 0; i < 4; i++) chk("alt_master", mlog[m0+i], exp_m[i]);

      // Five reads, responses withheld.
      g0 = glog.size();
      s_valid = 2'b01; s_re = 2'b01; s_we = 2'b00; s_addr[0] = 32'h100;
      repeat (7) tick();
      chk("fill_grants", glog.size() - g0, 4);
      mid();
      chk("full_stall", s_ready, 2'b00);
      tick();
      m_rvalid = 1'b1; m_rdata = 32'h1111;
      mid();
      chk("pop_accept", s_ready, 2'b01);
      chk("pop_route", s_rvalid, 2'b01);
      chk("pop_mrready", m_rready, 1);
      chk("fifth_grant", glog.size() - g0, 5);

      // Write passes while reads are stalled on a full FIFO.
      tick();
      m_rvalid = 1'b0;
      s_valid = 2'b11; s_re = 2'b01; s_we = 2'b10; s_addr[1] = 32'h40;
      mid();
      chk("full_wr_ready", s_ready, 2'b10);
      tick();
      s_valid = 2'b01;
      mid();
      chk("full_wr_fwd", mlog[$], 32'h40);
      chk("full_wr_addr", m_caddr, 32'h40);
      chk("full_rd_stall", s_ready, 2'b00);
      tick();
      s_valid = 2'b00; m_rvalid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         m_rdata = 32'h2000 + i;
         tick();
      end
      m_rvalid = 1'b0;

      // Response routing by port order.
      s_valid = 2'b10; s_re = 2'b10; s_we = 2'b00; s_addr[1] = 32'h10;
      tick();
      s_valid = 2'b01; s_re = 2'b01; s_addr[0] = 32'h20;
      tick();
      s_valid = 2'b00; m_rvalid = 1'b1; m_rdata = 32'hAAAA;
      mid();
      chk("route_aaaa_v", s_rvalid, 2'b10);
      chk("route_aaaa_d", s_rdata[1], 32'hAAAA);
      tick();
      m_rdata = 32'hBBBB;
      mid();
      chk("route_bbbb_v", s_rvalid, 2'b01);
      chk("route_bbbb_d", s_rdata[0], 32'hBBBB);
      tick();
      m_rvalid = 1'b0;

      // Master back-pressure and slave result back-pressure.
      s_valid = 2'b01; s_re = 2'b01; s_we = 2'b00; s_addr[0] = 32'h30;
      tick();
      s_valid = 2'b00;
      tick();
      m_cready = 1'b0;
      s_valid = 2'b01; s_re = 2'b00; s_we = 2'b01; s_addr[0] = 32'h55;
      tick();
      s_valid = 2'b10; s_we = 2'b10; s_addr[1] = 32'h66;
      m_rvalid = 1'b1; m_rdata = 32'hCCCC; s_rready = 2'b10;
      g0 = glog.size();
      for (int i = 0; i < 3; i++) begin
         mid();
         chk("hold_addr", m_caddr, 32'h55);
         chk("hold_valid", m_cvalid, 1);
         chk("hold_noready", s_ready, 2'b00);
         chk("hold_mrready", m_rready, 0);
         tick();
      end
      chk("hold_nogrant", glog.size() - g0, 0);
      m_cready = 1'b1; s_rready = 2'b11;
      mid();
      chk("release_grant", s_ready, 2'b10);
      chk("release_mrready", m_rready, 1);
      tick();
      s_valid = 2'b00; m_rvalid = 1'b0;
      tick();

      // Reset with reads outstanding.
      s_valid = 2'b11; s_re = 2'b11; s_we = 2'b00;
      s_addr[0] = 32'h70; s_addr[1] = 32'h71;
      tick(); tick();
      s_valid = 2'b00;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      s_valid = 2'b11; s_re = 2'b00; s_we = 2'b11;
      m_rvalid = 1'b1; m_rdata = 32'hDEAD;
      mid();
      chk("post_rst_mvalid", m_cvalid, 0);
      chk("post_rst_mrready", m_rready, 0);
      chk("post_rst_norte", s_rvalid, 2'b00);
      chk("post_rst_grant0", s_ready, 2'b01);
`ifdef MEM_RR_ARBITER_PERF_EN
      chk("perf_gcnt", gcnt, 0);
      chk("perf_ffc", ffc, 0);
`endif
      tick();
      s_valid = 2'b00; m_rvalid = 1'b0;
      tick(); tick();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
